dram_responder: RTL and testbench
=================================

Name: dram_responder

Overview:
- Responder end of the core's data-RAM request interface: accepts `dram_req`/`dram_write`/`dram_wstrb`/`dram_addr`/`dram_wdata` from the EX stage and completes the handshake with `dram_ready`.
- Word-organised on-chip data memory with byte-write strobes and a programmable number of wait states, so the pipeline stall path gets exercised.
- Read data is registered and returned to the MEM stage the cycle after the handshake.

Parameters:
- `XLEN`, 32: data/address width; must equal the core's `XLEN`.
- `DEPTH`, 1024: memory size in `XLEN`-bit words; power of two.
- `WAIT_CYCLES`, 0: cycles `dram_ready` stays low after a new request is first seen; 0 means zero-wait.
- `INIT_FILE`, "": optional hex image loaded at elaboration; empty means memory is left uninitialised.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous reset, active-high
- `dram_req`  in  1  request valid; requester may withdraw it before handshake
- `dram_write`  in  1  1=store, 0=load
- `dram_wstrb`  in  XLEN/8  byte write enables, bit i = byte lane i
- `dram_addr`  in  XLEN  byte address; word index = `addr[log2(DEPTH)+1:2]`
- `dram_wdata`  in  XLEN  lane-replicated store data
- `dram_ready`  out  1  handshake; transfer occurs when `req & ready`
- `dram_rdata`  out  XLEN  load data, full word, valid the cycle after a read handshake
- `dram_rvalid`  out  1  one-cycle pulse marking fresh `dram_rdata`

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE, wait counter=0.
  - `dram_rdata`=0, `dram_rvalid`=0.
  - `dram_ready`=1 if `WAIT_CYCLES`==0, else 0.
  - Memory contents are not reset.
- Handshake: a transfer completes in any cycle with `dram_req & dram_ready`. All request fields are sampled in that cycle only.
- Address decode: `addr[1:0]` is ignored, because alignment is the requester's job. Address bits above the index range are ignored, so accesses alias modulo `DEPTH` words.
- Write: on a write handshake, for each lane i with `wstrb[i]`=1, `mem[idx][8i+7:8i]` <= `wdata[8i+7:8i]`. Lanes with `wstrb[i]`=0 are unchanged. `wstrb`=0 is a legal no-op that still handshakes.
- Read: on a read handshake, `dram_rdata` <= `mem[idx]` (full word; the MEM stage extracts the byte or half). `dram_rvalid`=1 for exactly the next cycle. `dram_rdata` holds its value until the next read handshake; writes never change it.
- Read-after-write to the same word in back-to-back handshakes returns the newly written data.
- `dram_wstrb` is ignored on reads.
- FSM, `WAIT_CYCLES`=0:
  - Single state IDLE; `dram_ready`=1 constantly.
  - One transfer per cycle is possible.
- FSM, `WAIT_CYCLES`=N>0:
  - IDLE: `ready`=0. If `req`, go to WAIT with cnt<=N-1; otherwise stay.
  - WAIT: `ready`=(cnt==0).
    - `req`=0: abort. Go to IDLE with no memory access and no `rvalid`.
    - `req`=1, cnt>0: cnt<=cnt-1.
    - `req`=1, cnt==0: handshake, then go to IDLE.
  - Timing: first req at cycle 0, so `ready`=1 at cycle N; the handshake lands in cycle N.
  - Back-to-back: after a handshake the next request restarts the count, so sustained throughput is one transfer per N+1 cycles.
- Request fields may change while waiting (for example after a flush and reissue with `req` held high). Only the values present in the handshake cycle are used; no restart of the count is required.
- Reset mid-WAIT: return to IDLE immediately; no write occurs and `rvalid` stays 0.
- The counter is `$clog2(WAIT_CYCLES+1)` bits wide. No other state exists.

Test Plan:
- `WAIT_CYCLES`=0: write 0xDEADBEEF to 0x40 with wstrb=0xF, then read 0x40 the next cycle -> `ready` high in both cycles; cycle after the read, `rdata`=0xDEADBEEF and `rvalid`=1 for one cycle.
- Byte/half strobes: preload 0x11223344 at 0x80, write wdata=0xAAAAAAAA wstrb=0x2, then wdata=0xBBBBBBBB wstrb=0xC, then read -> 0xBBBBAA44.
- `WAIT_CYCLES`=3: read 0x40 with `req` held from cycle 0 -> `ready`=0 in cycles 0–2, `ready`=1 in cycle 3, `rvalid` in cycle 4. A second request starting in cycle 4 handshakes in cycle 7.
- Abort: `WAIT_CYCLES`=3, write request to 0x100 dropped in cycle 2 -> memory at 0x100 unchanged, no handshake, FSM back in IDLE. A new read starting in cycle 3 gets `ready` in cycle 6.
- Aliasing and hold: `DEPTH`=1024, write 0x5 to 0x1000, read 0x0 -> returns 0x5. Then issue several writes -> `rdata` stays 0x5 and `rvalid` stays 0.
- Async reset asserted mid-WAIT (`WAIT_CYCLES`=2) -> `ready`, `rvalid` and `rdata` go to 0 without waiting for a clock edge. After deassert, the next request takes the full 2 wait cycles.

Source files
------------

// File: rtl/dram_responder.sv
// Data-RAM responder for the core's load/store port: word-organised memory with
// byte-lane write strobes, a registered read return and a programmable wait-state count.
module dram_responder #(
  parameter int    XLEN        = 32,
  parameter int    DEPTH       = 1024,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dram_req,
  input  logic              dram_write,
  input  logic [XLEN/8-1:0] dram_wstrb,
  input  logic [XLEN-1:0]   dram_addr,
  input  logic [XLEN-1:0]   dram_wdata,
  output logic              dram_ready,
  output logic [XLEN-1:0]   dram_rdata,
  output logic              dram_rvalid
);

  localparam int IW = $clog2(DEPTH);
  localparam int NB = XLEN / 8;
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;
  logic            ready;
  logic            hs;
  logic [IW-1:0]   idx;
  logic [XLEN-1:0] mem [DEPTH];

  // Low two bits and bits above the index are dropped, so accesses alias modulo DEPTH.
  assign idx = dram_addr[IW+1:2];

  generate
    if (XLEN > IW + 2) begin : g_unused_hi
      logic unused_addr;
      assign unused_addr = ^{dram_addr[XLEN-1:IW+2], dram_addr[1:0]};
    end else begin : g_unused_lo
      logic unused_addr;
      assign unused_addr = ^dram_addr[1:0];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    if (WAIT_CYCLES == 0) begin
      ready   = 1'b1;
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (dram_req) begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
        S_WAIT: begin
          ready = (cnt_q == '0);
          // A dropped request aborts; a held one counts down and completes at zero.
          if (!dram_req) begin
            state_d = S_IDLE;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    hs       = dram_req & ready & ~rst;
    rvalid_d = hs & ~dram_write;
    rdata_d  = rvalid_d ? mem[idx] : rdata_q;
  end

  assign dram_ready  = ready;
  assign dram_rdata  = rdata_q;
  assign dram_rvalid = rvalid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Storage is deliberately not reset; only strobed lanes are written.
  always_ff @(posedge clk) begin
    if (hs && dram_write) begin
      for (int i = 0; i < NB; i++) begin
        if (dram_wstrb[i]) mem[idx][8*i +: 8] <= dram_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dram_responder.sv
// Bench for dram_responder: three instances (0, 3 and 2 wait states) checked every
// cycle against a transaction-level memory model, plus hand-computed directed cases.
module tb_dram_responder;

  localparam int NI = 3;
  localparam int DEPTH = 1024;
  localparam int NW [NI] = '{0, 3, 2};

  logic        clk;
  logic        rst    [NI];
  logic        req    [NI];
  logic        wr     [NI];
  logic [3:0]  strb   [NI];
  logic [31:0] addr   [NI];
  logic [31:0] wdata  [NI];
  logic        ready  [NI];
  logic [31:0] rdata  [NI];
  logic        rvalid [NI];

  int n_tests = 0;
  int n_fail  = 0;

  dram_responder #(.XLEN(32), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst[0]), .dram_req(req[0]), .dram_write(wr[0]), .dram_wstrb(strb[0]),
    .dram_addr(addr[0]), .dram_wdata(wdata[0]), .dram_ready(ready[0]),
    .dram_rdata(rdata[0]), .dram_rvalid(rvalid[0]));
  dram_responder #(.XLEN(32), .DEPTH(DEPTH), .WAIT_CYCLES(3)) u1 (
    .clk(clk), .rst(rst[1]), .dram_req(req[1]), .dram_write(wr[1]), .dram_wstrb(strb[1]),
    .dram_addr(addr[1]), .dram_wdata(wdata[1]), .dram_ready(ready[1]),
    .dram_rdata(rdata[1]), .dram_rvalid(rvalid[1]));
  dram_responder #(.XLEN(32), .DEPTH(DEPTH), .WAIT_CYCLES(2)) u2 (
    .clk(clk), .rst(rst[2]), .dram_req(req[2]), .dram_write(wr[2]), .dram_wstrb(strb[2]),
    .dram_addr(addr[2]), .dram_wdata(wdata[2]), .dram_ready(ready[2]),
    .dram_rdata(rdata[2]), .dram_rvalid(rvalid[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s u%0d t=%0t got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  // Reference model: memory image with per-lane knowledge, expected read return,
  // and the length of the current uninterrupted request run per instance.
  logic [31:0] mem_m   [NI][DEPTH];
  logic [3:0]  known_m [NI][DEPTH];
  logic [31:0] exp_rd  [NI];
  logic        exp_rv  [NI];
  logic        rd_known[NI];
  int          pos     [NI];
  logic        run     [NI];

  initial begin
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < DEPTH; i++) known_m[k][i] = 4'h0;
      exp_rd[k] = '0; exp_rv[k] = 1'b0; rd_known[k] = 1'b1; pos[k] = 0; run[k] = 1'b0;
    end
  end

  int   m_idx;
  logic m_er;
  logic m_hs;

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rst[k]) begin
        exp_rd[k] = '0; exp_rv[k] = 1'b0; rd_known[k] = 1'b1; pos[k] = 0; run[k] = 1'b0;
      end else begin
        check("rvalid", k, 32'(rvalid[k]), 32'(exp_rv[k]));
        if (rd_known[k]) check("rdata", k, rdata[k], exp_rd[k]);
        m_er = 1'b0;
        if (NW[k] == 0) begin
          m_er = 1'b1;
        end else if (req[k]) begin
          pos[k] = run[k] ? pos[k] + 1 : 0;
          m_er = (pos[k] == NW[k]);
        end
        if (req[k] || NW[k] == 0) check("ready", k, 32'(ready[k]), 32'(m_er));
        m_hs  = req[k] & m_er;
        m_idx = int'((addr[k] >> 2) % DEPTH);
        exp_rv[k] = m_hs & ~wr[k];
        if (m_hs && !wr[k]) begin
          exp_rd[k]   = mem_m[k][m_idx];
          rd_known[k] = (known_m[k][m_idx] == 4'hF);
        end
        if (m_hs && wr[k]) begin
          for (int l = 0; l < 4; l++) begin
            if (strb[k][l]) begin
              mem_m[k][m_idx][8*l +: 8] = wdata[k][8*l +: 8];
              known_m[k][m_idx][l]      = 1'b1;
            end
          end
        end
        run[k] = req[k] & ~m_hs;
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input int k, input logic w, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] d);
    int   guard = 0;
    logic done  = 1'b0;
    req[k] = 1'b1; wr[k] = w; strb[k] = s; addr[k] = a; wdata[k] = d;
    while (!done) begin
      #3;
      if (ready[k]) done = 1'b1;
      next();
      guard++;
      if (!done && guard > 20) begin
        check("handshake_timeout", k, 32'(guard), 32'(NW[k] + 1));
        done = 1'b1;
      end
    end
    req[k] = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; wr[k] = 1'b0; strb[k] = '0; addr[k] = '0; wdata[k] = '0;
    end
    #2;
    check("rst_ready", 0, 32'(ready[0]), 32'd1);
    check("rst_ready", 1, 32'(ready[1]), 32'd0);
    check("rst_rvalid", 1, 32'(rvalid[1]), 32'd0);
    check("rst_rdata", 2, rdata[2], 32'd0);
    next(); next();
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    next();

    // Fill the word pool used by every later test with recognisable values.
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 72; i++)
        xfer(k, 1'b1, 4'hF, 32'(i * 4), 32'h1000_0000 + 32'(k * 256) + 32'(i));

    // Zero-wait store then load of the same word in consecutive cycles.
    req[0] = 1'b1; wr[0] = 1'b1; strb[0] = 4'hF; addr[0] = 32'h40; wdata[0] = 32'hDEADBEEF;
    #3 check("w0_ready_wr", 0, 32'(ready[0]), 32'd1);
    next();
    wr[0] = 1'b0; strb[0] = 4'h0;
    #3 check("w0_ready_rd", 0, 32'(ready[0]), 32'd1);
    next();
    req[0] = 1'b0;
    #3;
    check("w0_rdata", 0, rdata[0], 32'hDEADBEEF);
    check("w0_rvalid", 0, 32'(rvalid[0]), 32'd1);
    next();
    #3 check("w0_rvalid_pulse", 0, 32'(rvalid[0]), 32'd0);
    next();

    // Byte and half strobes merge into the preloaded word.
    xfer(0, 1'b1, 4'hF, 32'h80, 32'h11223344);
    xfer(0, 1'b1, 4'h2, 32'h80, 32'hAAAAAAAA);
    xfer(0, 1'b1, 4'hC, 32'h80, 32'hBBBBBBBB);
    xfer(0, 1'b0, 4'hF, 32'h80, 32'h0);
    #3 check("strobe_merge", 0, rdata[0], 32'hBBBBAA44);
    next();

    // Three wait states: handshake in cycle 3, second request handshakes in cycle 7.
    req[1] = 1'b1; wr[1] = 1'b0; strb[1] = 4'h0; addr[1] = 32'h40;
    for (int c = 0; c < 8; c++) begin
      if (c == 4) addr[1] = 32'h44;
      #3;
      check("w3_ready", 1, 32'(ready[1]), 32'((c == 3) || (c == 7)));
      if (c == 4) check("w3_rvalid", 1, 32'(rvalid[1]), 32'd1);
      next();
    end
    req[1] = 1'b0;
    #3 check("w3_rdata2", 1, rdata[1], 32'h1000_0111);
    next();

    // Abort: a dropped store leaves memory alone; the following load waits the full count.
    xfer(1, 1'b1, 4'hF, 32'h100, 32'h0BADF00D);
    req[1] = 1'b1; wr[1] = 1'b1; strb[1] = 4'hF; addr[1] = 32'h100; wdata[1] = 32'hFFFFFFFF;
    for (int c = 0; c < 7; c++) begin
      if (c == 2) req[1] = 1'b0;
      if (c == 3) begin req[1] = 1'b1; wr[1] = 1'b0; end
      #3;
      if (c != 2) check("abort_ready", 1, 32'(ready[1]), 32'(c == 6));
      next();
    end
    req[1] = 1'b0;
    #3;
    check("abort_rdata", 1, rdata[1], 32'h0BADF00D);
    check("abort_rvalid", 1, 32'(rvalid[1]), 32'd1);
    next();

    // Aliasing modulo DEPTH words, then read data holds across stores.
    xfer(0, 1'b1, 4'hF, 32'h1000, 32'h5);
    xfer(0, 1'b0, 4'h0, 32'h0, 32'h0);
    #3;
    check("alias_rdata", 0, rdata[0], 32'h5);
    check("alias_rvalid", 0, 32'(rvalid[0]), 32'd1);
    next();
    for (int j = 0; j < 4; j++) begin
      req[0] = 1'b1; wr[0] = 1'b1; strb[0] = 4'hF; addr[0] = 32'(8 + 4 * j); wdata[0] = $urandom;
      #3;
      check("hold_rdata", 0, rdata[0], 32'h5);
      check("hold_rvalid", 0, 32'(rvalid[0]), 32'd0);
      next();
    end
    req[0] = 1'b0;
    next();

    // Async reset in the middle of a two-wait-state request.
    xfer(2, 1'b0, 4'h0, 32'h14, 32'h0);
    #3 check("pre_rst_rdata", 2, rdata[2], 32'h1000_0205);
    next();
    req[2] = 1'b1; wr[2] = 1'b1; strb[2] = 4'hF; addr[2] = 32'h14; wdata[2] = 32'hCAFEF00D;
    next();
    #1 rst[2] = 1'b1;
    req[2] = 1'b0;
    #1;
    check("async_rst_ready", 2, 32'(ready[2]), 32'd0);
    check("async_rst_rvalid", 2, 32'(rvalid[2]), 32'd0);
    check("async_rst_rdata", 2, rdata[2], 32'd0);
    next(); next();
    rst[2] = 1'b0;
    req[2] = 1'b1; wr[2] = 1'b0; strb[2] = 4'h0; addr[2] = 32'h14;
    for (int c = 0; c < 3; c++) begin
      #3 check("post_rst_ready", 2, 32'(ready[2]), 32'(c == 2));
      next();
    end
    req[2] = 1'b0;
    #3 check("post_rst_rdata", 2, rdata[2], 32'h1000_0205);
    next();

    // Random traffic: requests may drop or change fields at any cycle.
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < NI; k++) begin
        req[k]   = ($urandom_range(0, 9) < 7);
        wr[k]    = $urandom_range(0, 1) == 1;
        strb[k]  = 4'($urandom_range(0, 15));
        a        = $urandom;
        a[11:2]  = 10'($urandom_range(0, 71));
        addr[k]  = a;
        wdata[k] = $urandom;
      end
      next();
    end
    for (int k = 0; k < NI; k++) req[k] = 1'b0;
    next(); next();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
